// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants and frame state type for the PS/2 keyboard receiver
package ps2_pkg;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_REL = 8'hF0;

  localparam int         PS2_DATA_BITS = 8;
  localparam logic [2:0] PS2_LAST_BIT  = 3'(PS2_DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

endpackage

// File: rtl/ps2_rx_frame.sv
// rtl/ps2_rx_frame.sv - PS/2 line conditioning, 11-bit frame deframer and stall timeout
module ps2_rx_frame #(
  parameter int FILTER  = 4,
  parameter int TIMEOUT = 50000,
  parameter int TW      = 16
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       rx_err,
  output logic       busy
);
  import ps2_pkg::*;

  localparam int          FW       = (FILTER > 1) ? $clog2(FILTER) : 1;
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER - 1);
  localparam logic [TW-1:0] TO_LIM   = TW'(TIMEOUT);
  localparam logic [TW-1:0] TO_MAX   = {TW{1'b1}};

  logic          clk_s1, clk_s2, data_s1, data_s2;
  logic          clk_flt, clk_flt_d;
  logic [FW-1:0] flt_cnt;

  ps2_state_t    state;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic          par_acc;
  logic          par_bad;
  logic [TW-1:0] to_cnt;

  logic          fall;
  logic          sbit;
  logic          timeout;

  // Conditioning: a new clock level is accepted only after FILTER samples disagree in a row.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_s1    <= 1'b1;
      clk_s2    <= 1'b1;
      data_s1   <= 1'b1;
      data_s2   <= 1'b1;
      clk_flt   <= 1'b1;
      clk_flt_d <= 1'b1;
      flt_cnt   <= '0;
    end else begin
      clk_s1    <= ps2_clk;
      clk_s2    <= clk_s1;
      data_s1   <= ps2_data;
      data_s2   <= data_s1;
      clk_flt_d <= clk_flt;
      if (clk_s2 == clk_flt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_LAST) begin
        clk_flt <= clk_s2;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + FW'(1);
      end
    end
  end

  assign fall    = clk_flt_d & ~clk_flt;
  assign sbit    = data_s2;
  assign busy    = (state != IDLE);
  // An edge on the same cycle as expiry keeps the frame alive.
  assign timeout = busy && !fall && (to_cnt >= TO_LIM);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= IDLE;
      shift     <= '0;
      bit_cnt   <= '0;
      par_acc   <= 1'b1;
      par_bad   <= 1'b0;
      to_cnt    <= '0;
      rx_byte   <= '0;
      rx_strobe <= 1'b0;
      rx_err    <= 1'b0;
    end else begin
      rx_strobe <= 1'b0;
      rx_err    <= 1'b0;

      if (fall) begin
        to_cnt <= '0;
      end else if (busy && to_cnt != TO_MAX) begin
        to_cnt <= to_cnt + TW'(1);
      end

      if (timeout) begin
        state  <= IDLE;
        rx_err <= 1'b1;
        to_cnt <= '0;
      end else if (fall) begin
        case (state)
          IDLE: begin
            // High data here is the sender's trailing edge, not a start bit.
            if (!sbit) begin
              state   <= DATA;
              bit_cnt <= '0;
              par_acc <= 1'b1;
              par_bad <= 1'b0;
            end
          end
          DATA: begin
            shift   <= {sbit, shift[7:1]};
            par_acc <= par_acc ^ sbit;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == PS2_LAST_BIT) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            par_bad <= (sbit != par_acc);
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!par_bad && sbit) begin
              rx_byte   <= shift;
              rx_strobe <= 1'b1;
            end else begin
              rx_err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_kbd_decoder.sv
// rtl/ps2_kbd_decoder.sv - PS/2 keyboard receiver folding E0/F0 prefixes into key events
module ps2_kbd_decoder #(
  parameter int FILTER  = 4,
  parameter int TIMEOUT = 50000,
  parameter int TW      = 16
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       rx_err,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic       key_strobe,
  output logic       busy
);
  import ps2_pkg::*;

  logic ext_pend;
  logic rel_pend;

  ps2_rx_frame #(
    .FILTER  (FILTER),
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_rx_frame (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .rx_strobe (rx_strobe),
    .rx_err    (rx_err),
    .busy      (busy)
  );

  // Prefixes only arm flags; the next plain byte carries them out as one event.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ext_pend    <= 1'b0;
      rel_pend    <= 1'b0;
      key_code    <= '0;
      key_ext     <= 1'b0;
      key_release <= 1'b0;
      key_strobe  <= 1'b0;
    end else begin
      key_strobe <= 1'b0;
      if (rx_err) begin
        ext_pend <= 1'b0;
        rel_pend <= 1'b0;
      end else if (rx_strobe) begin
        if (rx_byte == PS2_PFX_EXT) begin
          ext_pend <= 1'b1;
        end else if (rx_byte == PS2_PFX_REL) begin
          rel_pend <= 1'b1;
        end else begin
          key_code    <= rx_byte;
          key_ext     <= ext_pend;
          key_release <= rel_pend;
          key_strobe  <= 1'b1;
          ext_pend    <= 1'b0;
          rel_pend    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// tb/tb_ps2_kbd_decoder.sv - self-checking bench for ps2_kbd_decoder
module tb_ps2_kbd_decoder;

  localparam int TO      = 2500;
  localparam int SLOW    = 1001;
  localparam int FAST    = 20;

  logic       clk_sys = 1'b0;
  logic       reset   = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_strobe;
  logic       rx_err;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_release;
  logic       key_strobe;
  logic       busy;

  ps2_kbd_decoder #(.FILTER(4), .TIMEOUT(TO), .TW(16)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .rx_byte     (rx_byte),
    .rx_strobe   (rx_strobe),
    .rx_err      (rx_err),
    .key_code    (key_code),
    .key_ext     (key_ext),
    .key_release (key_release),
    .key_strobe  (key_strobe),
    .busy        (busy)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [7:0] d;
    bit         pbad;
    bit         sbad;
    bit         e_rx;
    bit         e_err;
    bit         e_key;
    logic [7:0] e_rxb;
    logic [7:0] e_code;
    bit         e_ext;
    bit         e_rel;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_rx = 0, n_err = 0, n_key = 0;
  int rx_cyc = 0, stop_cyc = 0;
  bit prev_rx_plain = 0;
  bit busy_seen = 0;

  // Byte-level reference: last good byte, pending prefixes, last key event.
  logic [7:0] m_last, m_code;
  bit         m_ext, m_rel, m_kext, m_krel;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    if (!reset) begin
      if (busy) busy_seen = 1;
      if (rx_strobe) begin
        n_rx++;
        rx_cyc = cyc;
      end
      if (rx_err) n_err++;
      if (key_strobe) begin
        n_key++;
        check("key_latency", {31'd0, prev_rx_plain}, 32'd1);
      end
      prev_rx_plain = rx_strobe && rx_byte != 8'hE0 && rx_byte != 8'hF0;
    end else begin
      prev_rx_plain = 0;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pbad, input bit stop,
                            input int nbits, input int half, input bit trail);
    logic [10:0] fr;
    fr = {stop, (~^d) ^ pbad, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      wait_cyc(half);
      ps2_clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      wait_cyc(half);
      ps2_clk = 1'b1;
    end
    if (trail) begin
      ps2_data = 1'b1;
      wait_cyc(half);
      ps2_clk = 1'b0;
      wait_cyc(half);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic apply_vec(input vec_t v, input int half, input string tag);
    int rx0, err0, key0;
    rx0 = n_rx; err0 = n_err; key0 = n_key;
    send_frame(v.d, v.pbad, !v.sbad, 11, half, 1'b1);
    wait_cyc(20);
    check({tag, "_rx_cnt"},  n_rx - rx0,   {31'd0, v.e_rx});
    check({tag, "_err_cnt"}, n_err - err0, {31'd0, v.e_err});
    check({tag, "_key_cnt"}, n_key - key0, {31'd0, v.e_key});
    check({tag, "_rx_byte"}, {24'd0, rx_byte}, {24'd0, v.e_rxb});
    check({tag, "_key"}, {22'd0, key_code, key_ext, key_release},
          {22'd0, v.e_code, v.e_ext, v.e_rel});
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    if (v.e_rx)
      check({tag, "_rx_latency"},
            {31'd0, (rx_cyc - stop_cyc >= 6) && (rx_cyc - stop_cyc <= 9)}, 32'd1);
  endtask

  function automatic vec_t model_step(input logic [7:0] d, input bit pbad, input bit sbad);
    vec_t v;
    v.d = d; v.pbad = pbad; v.sbad = sbad;
    v.e_rx = !pbad && !sbad; v.e_err = pbad || sbad; v.e_key = 0;
    if (v.e_rx) begin
      m_last = d;
      if (d == 8'hE0) m_ext = 1;
      else if (d == 8'hF0) m_rel = 1;
      else begin
        v.e_key = 1;
        m_code = d; m_kext = m_ext; m_krel = m_rel;
        m_ext = 0; m_rel = 0;
      end
    end else begin
      m_ext = 0; m_rel = 0;
    end
    v.e_rxb = m_last; v.e_code = m_code; v.e_ext = m_kext; v.e_rel = m_krel;
    return v;
  endfunction

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[13];
    vec_t v;
    int   err0, rx0, key0;

    tbl[0]  = '{8'h1C, 0, 0, 1, 0, 1, 8'h1C, 8'h1C, 0, 0};
    tbl[1]  = '{8'hE0, 0, 0, 1, 0, 0, 8'hE0, 8'h1C, 0, 0};
    tbl[2]  = '{8'hF0, 0, 0, 1, 0, 0, 8'hF0, 8'h1C, 0, 0};
    tbl[3]  = '{8'h75, 0, 0, 1, 0, 1, 8'h75, 8'h75, 1, 1};
    tbl[4]  = '{8'h1C, 1, 0, 0, 1, 0, 8'h75, 8'h75, 1, 1};
    tbl[5]  = '{8'hF0, 0, 0, 1, 0, 0, 8'hF0, 8'h75, 1, 1};
    tbl[6]  = '{8'h1C, 0, 0, 1, 0, 1, 8'h1C, 8'h1C, 0, 1};
    tbl[7]  = '{8'hE1, 0, 0, 1, 0, 1, 8'hE1, 8'hE1, 0, 0};
    tbl[8]  = '{8'hF0, 0, 0, 1, 0, 0, 8'hF0, 8'hE1, 0, 0};
    tbl[9]  = '{8'h55, 0, 1, 0, 1, 0, 8'hF0, 8'hE1, 0, 0};
    tbl[10] = '{8'h33, 0, 0, 1, 0, 1, 8'h33, 8'h33, 0, 0};
    tbl[11] = '{8'hE0, 0, 0, 1, 0, 0, 8'hE0, 8'h33, 0, 0};
    tbl[12] = '{8'h74, 0, 0, 1, 0, 1, 8'h74, 8'h74, 1, 0};

    reset = 1'b1;
    wait_cyc(5);
    check("reset_outputs", {13'd0, rx_byte, rx_strobe, rx_err, key_code, key_ext,
                            key_release, key_strobe, busy}, 32'd0);
    reset = 1'b0;
    wait_cyc(10);

    for (int i = 0; i < 13; i++)
      apply_vec(tbl[i], (i == 0) ? SLOW : FAST, $sformatf("tbl%0d", i));

    // Stalled frame after an E0: timeout must error and drop the prefix.
    v = '{8'hE0, 0, 0, 1, 0, 0, 8'hE0, 8'h74, 1, 0};
    apply_vec(v, FAST, "to_pfx");
    err0 = n_err; rx0 = n_rx;
    send_frame(8'h29, 0, 1, 4, FAST, 0);
    wait_cyc(10);
    check("to_busy_mid", {31'd0, busy}, 32'd1);
    wait_cyc(TO + 10);
    check("to_err_cnt", n_err - err0, 32'd1);
    check("to_rx_cnt", n_rx - rx0, 32'd0);
    check("to_busy_after", {31'd0, busy}, 32'd0);
    v = '{8'h29, 0, 0, 1, 0, 1, 8'h29, 8'h29, 0, 0};
    apply_vec(v, FAST, "to_next");

    // Short clock glitches and a lone trailing edge while idle.
    rx0 = n_rx; err0 = n_err; key0 = n_key; busy_seen = 0;
    for (int g = 1; g <= 3; g++) begin
      for (int r = 0; r < 2; r++) begin
        ps2_clk = 1'b0;
        wait_cyc(g);
        ps2_clk = 1'b1;
        wait_cyc(12);
      end
    end
    send_frame(8'h00, 0, 1, 0, FAST, 1);
    wait_cyc(20);
    check("glitch_events", (n_rx - rx0) + (n_err - err0) + (n_key - key0), 32'd0);
    check("glitch_busy", {31'd0, busy_seen}, 32'd0);

    // Reset in the middle of a frame, with an E0 pending beforehand.
    v = '{8'hE0, 0, 0, 1, 0, 0, 8'hE0, 8'h29, 0, 0};
    apply_vec(v, FAST, "rst_pfx");
    err0 = n_err;
    send_frame(8'hA5, 0, 1, 5, FAST, 0);
    wait_cyc(FAST);
    reset = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(2);
    check("rst_outputs", {13'd0, rx_byte, rx_strobe, rx_err, key_code, key_ext,
                          key_release, key_strobe, busy}, 32'd0);
    wait_cyc(20);
    check("rst_no_err", n_err - err0, 32'd0);
    v = '{8'h5A, 0, 0, 1, 0, 1, 8'h5A, 8'h5A, 0, 0};
    apply_vec(v, FAST, "rst_next");

    m_last = 8'h5A; m_code = 8'h5A; m_kext = 0; m_krel = 0; m_ext = 0; m_rel = 0;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] d;
      int         sel, e;
      sel = $urandom_range(0, 9);
      d   = (sel < 2) ? 8'hE0 : (sel == 2) ? 8'hF0 : 8'($urandom_range(0, 255));
      e   = $urandom_range(0, 7);
      v   = model_step(d, e == 0, e == 1);
      apply_vec(v, FAST, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_decoder.md
Name: ps2_kbd_decoder

Overview:
- Core-side PS/2 keyboard receiver and scancode decoder.
- Consumes the ps2_kbd_clk/ps2_kbd_data pair emitted by the HPS I/O block. Deframes 11-bit PS/2 frames into bytes, checks them, and folds the E0/F0 prefixes into single key events.
- Sits between the HPS I/O block and the machine's keyboard matrix emulation, all in the clk_sys domain.

Parameters:
- FILTER, 4: number of consecutive equal synchronized samples needed to accept a new ps2_clk level.
- TIMEOUT, 50000: clk_sys cycles without a filtered falling edge before a partial frame is aborted. Must exceed 2*(PS2DIV+1).
- TW, 16: width of the timeout counter.

Ports:
- clk_sys  in  1  system clock; every register is clocked on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ps2_clk  in  1  PS/2 clock from the HPS I/O block; idles high.
- ps2_data  in  1  PS/2 data; changes on the ps2_clk rising edge and is sampled on the falling edge.
- rx_byte  out  8  last received raw byte.
- rx_strobe  out  1  one-cycle pulse when rx_byte is updated with a good frame.
- rx_err  out  1  one-cycle pulse on a parity, stop or timeout error.
- key_code  out  8  scancode with prefixes removed.
- key_ext  out  1  E0 prefix preceded key_code.
- key_release  out  1  F0 prefix preceded key_code.
- key_strobe  out  1  one-cycle pulse when the key_* outputs update.
- busy  out  1  high while a frame is in progress.

Behaviour:
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-flop synchronizer.
  - ps2_clk is then filtered: the filtered level changes only after FILTER identical consecutive samples.
  - A falling edge is filtered-clock 1→0. Data is taken from the synchronized ps2_data on the same cycle as the falling edge.
- Frame state machine: IDLE, DATA, PARITY, STOP.
  - IDLE: falling edge with data=0 → DATA, bit count 0, parity accumulator 1. Falling edge with data=1 is ignored, because the sender emits one trailing high edge after the stop bit.
  - DATA: each falling edge shifts data into bit 7 of the shift register (LSB first) and XORs it into parity. After the 8th bit → PARITY.
  - PARITY: the sampled bit must equal the accumulator (odd parity overall). Record a mismatch, then → STOP.
  - STOP: data must be 1.
    - Good parity and stop: the next cycle drives rx_byte and pulses rx_strobe.
    - Otherwise: the next cycle pulses rx_err and leaves rx_byte unchanged.
    - Either way → IDLE.
- busy is high in DATA, PARITY and STOP.
- Timeout:
  - The counter clears on every falling edge and increments while busy.
  - Reaching TIMEOUT → IDLE, pulse rx_err, clear the prefix flags.
  - The counter saturates at 2^TW-1.
- Prefix decoder, acting on each rx_strobe:
  - Byte E0: set ext_pend.
  - Byte F0: set rel_pend.
  - Any other byte: on the next cycle, key_code=byte, key_ext=ext_pend, key_release=rel_pend, key_strobe=1, and both pending flags clear.
  - E1, AA, FA, FE and similar bytes are forwarded as plain codes.
  - Any rx_err also clears both pending flags.
- Latency:
  - rx_strobe: 1 cycle after the stop-bit falling edge.
  - key_strobe: 1 cycle after rx_strobe.
- Reset:
  - All outputs go to 0 and the FSM goes to IDLE. Shift register, pending flags and timeout counter clear. Filter state and synchronizers load 1 (idle level).
  - Reset mid-frame discards the frame with no rx_err.
  - Falling edges resume being recognized once the filter re-qualifies.
- Simultaneous events: a timeout and a falling edge on the same cycle resolve in favour of the edge.

Decomposition:
- Package ps2_pkg:
  - PS2_PFX_EXT = 8'hE0, PS2_PFX_REL = 8'hF0.
  - FSM state enum {IDLE, DATA, PARITY, STOP}.
  - Frame bit-count constants.
- Sub-module ps2_rx_frame: synchronizer, filter, frame FSM and timeout. Outputs rx_byte, rx_strobe, rx_err and busy.
- Top level: instantiates ps2_rx_frame and holds only the prefix decoder.

Test Plan:
- Frame 0x1C with parity 0 and stop 1 at 2002-cycle bit period → rx_strobe with rx_byte=1C, then key_strobe with key_code=1C, ext=0, rel=0.
- Frames E0, F0, 75 → exactly one key_strobe: key_code=75, ext=1, rel=1. No key_strobe for the prefix bytes.
- Frame 0x1C with parity forced to 1 → rx_err pulse, no rx_strobe, rx_byte keeps its previous value. A following F0 without a key byte, then a 1C, yields rel=1.
- 4 bits of a frame then clock held high for TIMEOUT+10 cycles → one rx_err, busy drops. The next full frame 0x29 decodes correctly.
- 1-3 cycle low glitches on ps2_clk while idle, plus the trailing high-data edge after the stop bit → no strobes, busy stays 0.
- reset asserted during bit 5 of a frame → outputs 0 and no rx_err. The next frame 0x5A decodes correctly.
